// File: rtl/dmac_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmac_cfg_pkg
// Purpose  : Shared register offsets, CTRL bit positions and channel states
//            for the DMAC configuration register file.
// Revision : 1.0
// ============================================================================
package dmac_cfg_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_IRQ_EN = 3;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/dmac_cfg_ch.sv
`default_nettype none
// ============================================================================
// Module   : dmac_cfg_ch
// Purpose  : One DMA channel: SRC/DST/LEN/CTRL registers, idle/busy state
//            machine, one-cycle start pulse and interrupt term.
// Revision : 1.0
// ============================================================================
module dmac_cfg_ch
    import dmac_cfg_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_src,
    input  logic             wr_dst,
    input  logic             wr_len,
    input  logic             wr_ctrl,
    input  logic [31:0]      wdata,
    input  logic             done_pulse,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             start,
    output logic             busy,
    output logic             done_flag,
    output logic             irq_en,
    output logic             irq_term
);

    ch_state_e        r_state;
    ch_state_e        w_state_next;
    logic             w_start_next;
    logic             r_start;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_done;
    logic             r_irq_en;

    always_comb begin
        w_state_next = r_state;
        w_start_next = 1'b0;
        case (r_state)
            CH_IDLE: begin
                if (wr_ctrl && wdata[CTRL_START]) begin
                    w_state_next = CH_BUSY;
                    w_start_next = 1'b1;
                end
            end
            CH_BUSY: begin
                if (done_pulse) begin
                    w_state_next = CH_IDLE;
                end
            end
            default: w_state_next = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CH_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_start_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (wr_src) r_src <= wdata;
            if (wr_dst) r_dst <= wdata;
            if (wr_len) r_len <= wdata[LEN_W-1:0];
            if (wr_ctrl) r_irq_en <= wdata[CTRL_IRQ_EN];
            // A completion landing together with a W1C leaves DONE set.
            if (r_state == CH_BUSY && done_pulse) begin
                r_done <= 1'b1;
            end else if (wr_ctrl && wdata[CTRL_DONE]) begin
                r_done <= 1'b0;
            end
        end
    end

    assign src       = r_src;
    assign dst       = r_dst;
    assign len       = r_len;
    assign start     = r_start;
    assign busy      = (r_state == CH_BUSY);
    assign done_flag = r_done;
    assign irq_en    = r_irq_en;
    assign irq_term  = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: rtl/dmac_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module   : dmac_cfg_regfile
// Purpose  : Multi-channel DMAC configuration register file: address decode,
//            registered read mux and registered interrupt reduction.
// Revision : 1.0
// ============================================================================
module dmac_cfg_regfile
    import dmac_cfg_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wren_i,
    input  logic                    rden_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_o,
    input  logic [NUM_CH-1:0]       done_i,
    output logic [NUM_CH-1:0]       start_o,
    output logic [NUM_CH*32-1:0]    src_o,
    output logic [NUM_CH*32-1:0]    dst_o,
    output logic [NUM_CH*LEN_W-1:0] len_o,
    output logic                    irq_o
);

    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0]   w_ch;
    logic [1:0]        w_reg;
    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_irq_en;
    logic [NUM_CH-1:0] w_irq_term;
    logic [31:0]       w_rd_data;
    logic [31:0]       r_rdata;
    logic              r_irq;

    assign w_ch  = addr_i[ADDR_W-1:2];
    assign w_reg = addr_i[1:0];

    // Channel addresses at or above NUM_CH match no instance, so they decode to nothing.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic w_sel;
            assign w_sel = wren_i && (w_ch == CH_W'(c));

            dmac_cfg_ch #(
                .LEN_W (LEN_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .wr_src     (w_sel && (w_reg == REG_SRC)),
                .wr_dst     (w_sel && (w_reg == REG_DST)),
                .wr_len     (w_sel && (w_reg == REG_LEN)),
                .wr_ctrl    (w_sel && (w_reg == REG_CTRL)),
                .wdata      (wdata_i),
                .done_pulse (done_i[c]),
                .src        (src_o[32*c +: 32]),
                .dst        (dst_o[32*c +: 32]),
                .len        (len_o[LEN_W*c +: LEN_W]),
                .start      (start_o[c]),
                .busy       (w_busy[c]),
                .done_flag  (w_done[c]),
                .irq_en     (w_irq_en[c]),
                .irq_term   (w_irq_term[c])
            );
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == CH_W'(c)) begin
                case (w_reg)
                    REG_SRC: w_rd_data = src_o[32*c +: 32];
                    REG_DST: w_rd_data = dst_o[32*c +: 32];
                    REG_LEN: w_rd_data = 32'(len_o[LEN_W*c +: LEN_W]);
                    REG_CTRL: begin
                        w_rd_data[CTRL_BUSY]   = w_busy[c];
                        w_rd_data[CTRL_DONE]   = w_done[c];
                        w_rd_data[CTRL_IRQ_EN] = w_irq_en[c];
                    end
                    default: w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_rdata <= rden_i ? w_rd_data : 32'd0;
            r_irq   <= |w_irq_term;
        end
    end

    assign rdata_o = r_rdata;
    assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_dmac_cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmac_cfg_regfile
// Purpose  : Self-checking bench: directed literal checks plus random traffic
//            compared every cycle against an array-based register model.
// Revision : 1.0
// ============================================================================
module tb_dmac_cfg_regfile;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wren_i;
    logic                    rden_i;
    logic [ADDR_W-1:0]       addr_i;
    logic [31:0]             wdata_i;
    logic [31:0]             rdata_o;
    logic [NUM_CH-1:0]       done_i;
    logic [NUM_CH-1:0]       start_o;
    logic [NUM_CH*32-1:0]    src_o;
    logic [NUM_CH*32-1:0]    dst_o;
    logic [NUM_CH*LEN_W-1:0] len_o;
    logic                    irq_o;

    dmac_cfg_regfile #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wren_i  (wren_i),
        .rden_i  (rden_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .done_i  (done_i),
        .start_o (start_o),
        .src_o   (src_o),
        .dst_o   (dst_o),
        .len_o   (len_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]       m_src [NUM_CH];
    logic [31:0]       m_dst [NUM_CH];
    logic [31:0]       m_len [NUM_CH];
    logic [NUM_CH-1:0] m_busy, m_done, m_ien, m_pre_busy;
    logic [31:0]       exp_rdata;
    logic [NUM_CH-1:0] exp_start;
    logic              exp_irq;
    bit                m_valid = 1'b0;
    int                m_ch;
    int                m_r;
    localparam logic [31:0] LEN_MASK = 32'((64'd1 << LEN_W) - 64'd1);

    function automatic logic [31:0] reg_value(input int ch, input int r);
        case (r)
            0: return m_src[ch];
            1: return m_dst[ch];
            2: return m_len[ch];
            default: return 32'(m_ien[ch]) * 8 + 32'(m_done[ch]) * 4 + 32'(m_busy[ch]) * 2;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_src[c] = 0;
                m_dst[c] = 0;
                m_len[c] = 0;
            end
            m_busy = '0; m_done = '0; m_ien = '0;
            exp_rdata = '0; exp_start = '0; exp_irq = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_ch = int'(addr_i) / 4;
            m_r  = int'(addr_i) % 4;
            exp_irq = |(m_done & m_ien);
            exp_rdata = (rden_i && m_ch < NUM_CH) ? reg_value(m_ch, m_r) : 32'd0;
            exp_start = '0;
            m_pre_busy = m_busy;
            if (wren_i && m_ch < NUM_CH) begin
                case (m_r)
                    0: m_src[m_ch] = wdata_i;
                    1: m_dst[m_ch] = wdata_i;
                    2: m_len[m_ch] = wdata_i & LEN_MASK;
                    default: begin
                        m_ien[m_ch] = wdata_i[3];
                        if (wdata_i[2]) m_done[m_ch] = 1'b0;
                        if (wdata_i[0] && !m_pre_busy[m_ch]) begin
                            m_busy[m_ch] = 1'b1;
                            exp_start[m_ch] = 1'b1;
                        end
                    end
                endcase
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (done_i[c] && m_pre_busy[c]) begin
                    m_busy[c] = 1'b0;
                    m_done[c] = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NUM_CH*32-1:0]    e_src, e_dst;
    logic [NUM_CH*LEN_W-1:0] e_len;

    always @(negedge clk) begin
        if (m_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e_src[32*c +: 32]       = m_src[c];
                e_dst[32*c +: 32]       = m_dst[c];
                e_len[LEN_W*c +: LEN_W] = m_len[c][LEN_W-1:0];
            end
            check("model_rdata", 256'(rdata_o), 256'(exp_rdata));
            check("model_start", 256'(start_o), 256'(exp_start));
            check("model_irq",   256'(irq_o),   256'(exp_irq));
            check("model_src",   256'(src_o),   256'(e_src));
            check("model_dst",   256'(dst_o),   256'(e_dst));
            check("model_len",   256'(len_o),   256'(e_len));
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0]       snap_rdata;
    logic [NUM_CH-1:0] snap_start;
    logic              snap_irq;
    logic [31:0]       acc;
    logic [NUM_CH-1:0] acc_start;
    logic              acc_irq;

    task automatic cyc(input logic w, input logic r, input int a, input logic [31:0] d,
                       input logic [NUM_CH-1:0] dn, input logic rs);
        @(negedge clk);
        snap_rdata = rdata_o;
        snap_start = start_o;
        snap_irq   = irq_o;
        rst     = rs;
        wren_i  = w;
        rden_i  = r;
        addr_i  = ADDR_W'(a);
        wdata_i = d;
        done_i  = dn;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 32'd0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wren_i = 1'b0; rden_i = 1'b0; addr_i = '0; wdata_i = '0; done_i = '0;
        repeat (3) cyc(1'b0, 1'b0, 0, 32'd0, '0, 1'b1);

        // Reset: every register reads zero.
        acc = '0;
        for (int i = 0; i <= 4 * NUM_CH; i++) begin
            cyc(1'b0, i < 4 * NUM_CH, i, 32'd0, '0, 1'b0);
            if (i > 0) acc = acc | snap_rdata;
        end
        check("reset_reads", 256'(acc), 256'(0));
        check("reset_start", 256'(snap_start), 256'(0));
        check("reset_irq",   256'(snap_irq),   256'(0));

        // SRC write/readback on channel 2, LEN truncation.
        cyc(1'b1, 1'b0, 8, 32'hDEAD_BEEF, '0, 1'b0);
        cyc(1'b0, 1'b1, 8, 32'd0, '0, 1'b0);
        idle();
        check("src_readback", 256'(snap_rdata), 256'(32'hDEAD_BEEF));
        check("src_o_ch2", 256'(src_o[95:64]), 256'(32'hDEAD_BEEF));
        cyc(1'b1, 1'b0, 10, 32'hFFFF_FFFF, '0, 1'b0);
        cyc(1'b0, 1'b1, 10, 32'd0, '0, 1'b0);
        idle();
        check("len_trunc", 256'(snap_rdata), 256'(32'h0000_FFFF));

        // START on channel 1 with IRQ_EN.
        cyc(1'b1, 1'b0, 7, 32'h9, '0, 1'b0);
        cyc(1'b0, 1'b1, 7, 32'd0, '0, 1'b0);
        check("start_pulse", 256'(snap_start), 256'(4'b0010));
        idle();
        check("start_one_cycle", 256'(snap_start), 256'(0));
        check("ctrl_busy", 256'(snap_rdata), 256'(32'hA));
        cyc(1'b1, 1'b0, 7, 32'h9, '0, 1'b0);
        idle();
        check("start_while_busy", 256'(snap_start), 256'(0));

        // Completion sets DONE, irq two cycles later.
        cyc(1'b0, 1'b0, 0, 32'd0, 4'b0010, 1'b0);
        cyc(1'b0, 1'b1, 7, 32'd0, '0, 1'b0);
        check("irq_not_yet", 256'(snap_irq), 256'(0));
        idle();
        check("ctrl_done", 256'(snap_rdata), 256'(32'hC));
        check("irq_rise", 256'(snap_irq), 256'(1));

        // W1C DONE, keep IRQ_EN.
        cyc(1'b1, 1'b0, 7, 32'hC, '0, 1'b0);
        cyc(1'b0, 1'b1, 7, 32'd0, '0, 1'b0);
        check("irq_hold", 256'(snap_irq), 256'(1));
        idle();
        check("ctrl_w1c", 256'(snap_rdata), 256'(32'h8));
        check("irq_fall", 256'(snap_irq), 256'(0));

        // Done pulse and W1C together: set wins.
        cyc(1'b1, 1'b0, 7, 32'h9, '0, 1'b0);
        cyc(1'b1, 1'b0, 7, 32'hC, 4'b0010, 1'b0);
        cyc(1'b0, 1'b1, 7, 32'd0, '0, 1'b0);
        idle();
        check("done_beats_w1c", 256'(snap_rdata), 256'(32'hC));

        // Out-of-range channel.
        cyc(1'b1, 1'b1, 4 * NUM_CH, 32'h1234_5678, '0, 1'b0);
        idle();
        check("oor_read", 256'(snap_rdata), 256'(0));
        cyc(1'b0, 1'b1, 0, 32'd0, '0, 1'b0);
        idle();
        check("oor_no_write", 256'(snap_rdata), 256'(0));

        // Reset mid-transfer, then a late completion.
        cyc(1'b1, 1'b0, 3, 32'h1, '0, 1'b0);
        cyc(1'b1, 1'b0, 15, 32'h1, '0, 1'b0);
        cyc(1'b0, 1'b0, 0, 32'd0, '0, 1'b1);
        cyc(1'b0, 1'b0, 0, 32'd0, 4'b1001, 1'b0);
        acc = '0; acc_start = snap_start; acc_irq = snap_irq;
        for (int i = 0; i <= NUM_CH; i++) begin
            cyc(1'b0, i < NUM_CH, 4 * i + 3, 32'd0, '0, 1'b0);
            if (i > 0) acc = acc | snap_rdata;
            acc_start = acc_start | snap_start;
            acc_irq   = acc_irq | snap_irq;
        end
        idle();
        acc_irq = acc_irq | snap_irq;
        check("rst_ctrl_clear", 256'(acc), 256'(0));
        check("rst_no_start",   256'(acc_start), 256'(0));
        check("rst_no_irq",     256'(acc_irq), 256'(0));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << ADDR_W) - 1))
                                            : int'($urandom_range(0, 4 * NUM_CH + 3)),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom,
                NUM_CH'($urandom & $urandom),
                $urandom_range(0, 299) == 0);
        end
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
